// File: rtl/lsb_extract_ctrl.sv
// LSB steganography extraction sequencer: pulls one hidden byte from each 64-bit pixel
// word and streams it out until a delimiter byte or the length limit ends the message.
module lsb_extract_ctrl #(
    parameter logic [7:0]  DELIM   = 8'h23,
    parameter int unsigned MAX_LEN = 1024,
    parameter int unsigned LEN_W   = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [63:0]      s_pixel,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [7:0]       m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic [LEN_W-1:0] msg_len
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic [LEN_W-1:0] MAX_LEN_C = LEN_W'(MAX_LEN);

    // Hidden bit i sits in the LSB of cover byte lane i.
    function automatic logic [7:0] extract_byte(input logic [63:0] pixel);
        logic [7:0] x;
        for (int i = 0; i < 8; i++) begin
            x[i] = pixel[8*i];
        end
        return x;
    endfunction

    state_t           state_r, state_s;
    logic [7:0]       m_data_r;
    logic             m_valid_r;
    logic             overflow_r;
    logic             done_r;
    logic [LEN_W-1:0] msg_len_r;

    logic             accept_s;
    logic [7:0]       x_s;
    logic             is_delim_s;
    logic [LEN_W-1:0] msg_len_inc_s;
    logic             hits_max_s;
    logic             load_s;
    logic             clear_s;
    logic             set_ovf_s;
    logic             drain_exit_s;

    assign s_ready       = (state_r == ST_RUN) && (!m_valid_r || m_ready);
    assign accept_s      = s_valid && s_ready;
    assign x_s           = extract_byte(s_pixel);
    assign is_delim_s    = (x_s == DELIM);
    assign msg_len_inc_s = msg_len_r + {{(LEN_W-1){1'b0}}, 1'b1};
    assign hits_max_s    = (msg_len_inc_s == MAX_LEN_C);

    assign m_data   = m_data_r;
    assign m_valid  = m_valid_r;
    assign busy     = (state_r != ST_IDLE);
    assign done     = done_r;
    assign overflow = overflow_r;
    assign msg_len  = msg_len_r;

    // Next-state and datapath strobes; done_r masks start so a start in the done cycle is dropped.
    always_comb begin
        state_s      = state_r;
        load_s       = 1'b0;
        clear_s      = 1'b0;
        set_ovf_s    = 1'b0;
        drain_exit_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start && !done_r) begin
                    state_s = ST_RUN;
                    clear_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (accept_s) begin
                    if (is_delim_s) begin
                        state_s = ST_DRAIN;
                    end else begin
                        load_s = 1'b1;
                        if (hits_max_s) begin
                            set_ovf_s = 1'b1;
                            state_s   = ST_DRAIN;
                        end else begin
                            state_s = ST_RUN;
                        end
                    end
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (!m_valid_r || m_ready) begin
                    state_s      = ST_IDLE;
                    drain_exit_s = 1'b1;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, output register, length counter and status flags.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r    <= ST_IDLE;
            m_data_r   <= 8'h00;
            m_valid_r  <= 1'b0;
            overflow_r <= 1'b0;
            done_r     <= 1'b0;
            msg_len_r  <= {LEN_W{1'b0}};
        end else begin
            state_r <= state_s;
            done_r  <= drain_exit_s;
            if (load_s) begin
                m_data_r  <= x_s;
                m_valid_r <= 1'b1;
            end else if (m_ready) begin
                m_valid_r <= 1'b0;
            end else begin
                m_valid_r <= m_valid_r;
            end
            if (clear_s) begin
                msg_len_r <= {LEN_W{1'b0}};
            end else if (load_s) begin
                msg_len_r <= msg_len_inc_s;
            end else begin
                msg_len_r <= msg_len_r;
            end
            if (clear_s) begin
                overflow_r <= 1'b0;
            end else if (set_ovf_s) begin
                overflow_r <= 1'b1;
            end else begin
                overflow_r <= overflow_r;
            end
        end
    end

endmodule

// File: tb/tb_lsb_extract_ctrl.sv
// Randomized self-checking bench for lsb_extract_ctrl against a message-level reference model.
module tb_lsb_extract_ctrl;

    localparam logic [7:0] DELIM   = 8'h23;
    localparam int         MAX_LEN = 4;
    localparam int         LEN_W   = 16;

    logic             clk = 1'b0;
    logic             resetn = 1'b0;
    logic             start = 1'b0;
    logic [63:0]      s_pixel = 64'h0;
    logic             s_valid = 1'b0;
    logic             s_ready;
    logic [7:0]       m_data;
    logic             m_valid;
    logic             m_ready = 1'b1;
    logic             busy;
    logic             done;
    logic             overflow;
    logic [LEN_W-1:0] msg_len;

    lsb_extract_ctrl #(.DELIM(DELIM), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
        .clk(clk), .resetn(resetn), .start(start),
        .s_pixel(s_pixel), .s_valid(s_valid), .s_ready(s_ready),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .busy(busy), .done(done), .overflow(overflow), .msg_len(msg_len)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];

    // Reference model: a message is "open" while words are taken, "ending" until the output empties.
    bit         mdl_ok = 1'b0;
    bit         mdl_open, mdl_ending, mdl_done;
    logic [7:0] mdl_q[$];
    logic [7:0] mdl_data;
    int         mdl_cnt;
    bit         mdl_ovf;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] decode(input logic [63:0] w);
        logic [7:0] b;
        for (int i = 0; i < 8; i++) b[i] = w[8*i];
        return b;
    endfunction

    function automatic logic [63:0] make_word(input logic [7:0] b);
        logic [63:0] w;
        logic [6:0]  r;
        for (int i = 0; i < 8; i++) begin
            r = 7'($urandom_range(0, 127));
            w[8*i +: 8] = {r, b[i]};
        end
        return w;
    endfunction

    task automatic model_step();
        bit         idle0, take, pop, drained;
        logic [7:0] b;
        if (!resetn) begin
            mdl_open = 0; mdl_ending = 0; mdl_done = 0; mdl_q.delete();
            mdl_data = 8'h00; mdl_cnt = 0; mdl_ovf = 0;
            return;
        end
        idle0   = !mdl_open && !mdl_ending;
        take    = s_valid && mdl_open && (mdl_q.size() == 0 || m_ready);
        pop     = (mdl_q.size() != 0) && m_ready;
        drained = mdl_ending && (mdl_q.size() == 0 || m_ready);
        if (pop) void'(mdl_q.pop_front());
        if (drained) mdl_ending = 0;
        if (idle0 && start && !mdl_done) begin
            mdl_open = 1; mdl_cnt = 0; mdl_ovf = 0;
        end
        if (take) begin
            b = decode(s_pixel);
            if (b == DELIM) begin
                mdl_open = 0; mdl_ending = 1;
            end else begin
                mdl_q.push_back(b);
                mdl_data = b;
                mdl_cnt++;
                if (mdl_cnt == MAX_LEN) begin
                    mdl_ovf = 1; mdl_open = 0; mdl_ending = 1;
                end
            end
        end
        mdl_done = drained;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
            mdl_ok = 1'b1;
        end
    end

    // Single compare process: every output, every cycle, away from the active edge.
    always @(negedge clk) begin
        if (mdl_ok) begin
            chk("s_ready", s_ready, mdl_open && (mdl_q.size() == 0 || m_ready));
            chk("m_valid", m_valid, mdl_q.size() != 0);
            chk("m_data", m_data, mdl_data);
            chk("busy", busy, mdl_open || mdl_ending);
            chk("done", done, mdl_done);
            chk("overflow", overflow, mdl_ovf);
            chk("msg_len", msg_len, mdl_cnt);
            if (done) done_cnt++;
            if (resetn && m_valid && m_ready) rx_q.push_back(m_data);
        end
    end

    task automatic run_msg(input int vpct, input int rpct, input bit stall, input bit poke);
        logic [63:0] wq[$];
        bit fin = 0;
        bit stalled = 0;
        int stall_left = 0;
        foreach (tx_q[i]) wq.push_back(make_word(tx_q[i]));
        rx_q.delete();
        done_cnt = 0;
        @(posedge clk); #1;
        start = 1'b1;
        for (int c = 0; c < 300 && !fin; c++) begin
            @(posedge clk); #1;
            start = poke && ($urandom_range(0, 99) < 15);
            if (stall_left > 0) begin
                m_ready = 1'b0;
                stall_left--;
            end else begin
                m_ready = ($urandom_range(0, 99) < rpct);
            end
            if (wq.size() > 0) begin
                s_valid = ($urandom_range(0, 99) < vpct);
                s_pixel = wq[0];
            end else begin
                s_valid = 1'b0;
                s_pixel = {$urandom, $urandom};
            end
            @(negedge clk);
            if (s_valid && s_ready) void'(wq.pop_front());
            if (stall && !stalled && m_valid) begin
                stalled = 1;
                stall_left = 5;
            end
            if (!busy) fin = 1;
        end
        if (poke) start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; s_valid = 1'b0; m_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("msg_end", fin, 1);
        chk("done_pulses", done_cnt, 1);
    endtask

    task automatic check_result();
        int n = 0;
        bit ovf = 0;
        foreach (tx_q[i]) begin
            if (tx_q[i] == DELIM) break;
            n++;
        end
        if (n >= MAX_LEN) begin
            n = MAX_LEN;
            ovf = 1;
        end
        chk("rx_count", rx_q.size(), n);
        for (int i = 0; i < n && i < rx_q.size(); i++) chk("rx_byte", rx_q[i], tx_q[i]);
        chk("final_len", msg_len, n);
        chk("final_ovf", overflow, ovf);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;

        chk("model_decode_H", decode(make_word(8'h48)), 8'h48);
        chk("model_decode_i", decode(make_word(8'h69)), 8'h69);

        // Reset in the middle of a message with a byte held in the output register.
        done_cnt = 0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0; m_ready = 1'b0; s_valid = 1'b1; s_pixel = make_word(8'h41);
        @(posedge clk); #1 s_valid = 1'b0;
        @(negedge clk);
        chk("pre_reset_mvalid", m_valid, 1);
        @(posedge clk); #1 resetn = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_mvalid", m_valid, 0);
        chk("rst_mdata", m_data, 8'h00);
        chk("rst_busy", busy, 0);
        chk("rst_sready", s_ready, 0);
        chk("rst_len", msg_len, 0);
        chk("rst_done_count", done_cnt, 0);
        @(posedge clk); #1 resetn = 1'b1; m_ready = 1'b1;
        repeat (2) @(posedge clk);

        // "Hi#" with the sink always ready.
        tx_q = '{8'h48, 8'h69, 8'h23};
        run_msg(100, 100, 0, 0);
        chk("basic_count", rx_q.size(), 2);
        if (rx_q.size() == 2) begin
            chk("basic_b0", rx_q[0], 8'h48);
            chk("basic_b1", rx_q[1], 8'h69);
        end
        chk("basic_len", msg_len, 2);
        chk("basic_ovf", overflow, 0);

        // Sink stalls for five cycles after the first byte.
        tx_q = '{8'h11, 8'hA5, 8'h7E, 8'h23};
        run_msg(100, 100, 1, 0);
        check_result();

        // Six plain bytes against a limit of four.
        tx_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        run_msg(100, 100, 0, 0);
        chk("ovf_count", rx_q.size(), 4);
        chk("ovf_len", msg_len, 4);
        chk("ovf_flag", overflow, 1);

        // Delimiter as the very first word.
        tx_q = '{8'h23};
        run_msg(100, 100, 0, 0);
        chk("delim_count", rx_q.size(), 0);
        chk("delim_len", msg_len, 0);

        // Start pulses while busy and in the done cycle.
        tx_q = '{8'h55, 8'hC3, 8'h23};
        run_msg(100, 100, 0, 1);
        chk("poke_len", msg_len, 2);
        chk("poke_busy", busy, 0);

        for (int m = 0; m < 25; m++) begin
            int len;
            logic [7:0] b;
            len = $urandom_range(0, 6);
            tx_q.delete();
            for (int i = 0; i < len; i++) begin
                b = 8'($urandom_range(0, 255));
                if (b == DELIM) b = 8'h24;
                tx_q.push_back(b);
            end
            tx_q.push_back(DELIM);
            run_msg($urandom_range(40, 100), $urandom_range(30, 100), $urandom_range(0, 1) == 1,
                    $urandom_range(0, 1) == 1);
            check_result();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
